// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the cache request/response handshake, holds one instruction for IF/ID.
// Optional IF_FETCH_CNT_EN adds fetch_cnt/wait_cnt performance counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [31:0] ADEL_CODE = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] PC_plus4,
    output logic [31:0] Instruction,
    output logic        is_delayslot,
    output logic [31:0] if_fetch_exc_type,
    output logic        fetch_valid
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] wait_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_FULL    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] br_target;
    logic        pending;
    logic        br_last;
    logic [31:0] inst_q;
    logic [31:0] exc_q;
    logic        ds_q;
    logic        valid_q;

    logic        misaligned;
    logic        consume;
    logic        redirect;
    logic [31:0] redirect_pc;

    function automatic logic is_branch(input logic [31:0] word);
        logic [5:0] op;
        logic [5:0] funct;
        op    = word[31:26];
        funct = word[5:0];
        case (op)
            6'b000001, 6'b000010, 6'b000011, 6'b000100,
            6'b000101, 6'b000110, 6'b000111: is_branch = 1'b1;
            6'b000000: is_branch = (funct == 6'b001000) || (funct == 6'b001001);
            default:   is_branch = 1'b0;
        endcase
    endfunction

    assign misaligned  = (pc[1:0] != 2'b00);
    assign inst_req    = (state == S_REQ) && !misaligned;
    assign inst_addr   = pc;
    assign PC_plus4    = pc + 32'd4;
    assign consume     = valid_q && !stall_i;
    // A pulse in the same cycle as the delay-slot consume is newer than any latched target.
    assign redirect    = ds_q && (pending || branch_taken_i);
    assign redirect_pc = branch_taken_i ? branch_target_i : br_target;

    assign Instruction       = inst_q;
    assign is_delayslot      = ds_q;
    assign if_fetch_exc_type = exc_q;
    assign fetch_valid       = valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            br_target <= 32'd0;
            pending   <= 1'b0;
            br_last   <= 1'b0;
            inst_q    <= 32'd0;
            exc_q     <= 32'd0;
            ds_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else if (flush_i) begin
            pc      <= flush_pc_i;
            pending <= 1'b0;
            br_last <= 1'b0;
            inst_q  <= 32'd0;
            exc_q   <= 32'd0;
            ds_q    <= 1'b0;
            valid_q <= 1'b0;
            // Any request the cache already accepted must have its data drained.
            case (state)
                S_REQ:     state <= (inst_req && inst_addr_ok) ? S_DISCARD : S_REQ;
                S_WAIT:    state <= inst_data_ok ? S_REQ : S_DISCARD;
                S_DISCARD: state <= inst_data_ok ? S_REQ : S_DISCARD;
                default:   state <= S_REQ;
            endcase
        end else begin
            if (branch_taken_i && !consume) begin
                pending   <= 1'b1;
                br_target <= branch_target_i;
            end
            case (state)
                S_REQ: begin
                    if (misaligned) begin
                        state   <= S_FULL;
                        valid_q <= 1'b1;
                        inst_q  <= 32'd0;
                        exc_q   <= ADEL_CODE;
                        ds_q    <= br_last;
                    end else if (inst_addr_ok) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        state   <= S_FULL;
                        valid_q <= 1'b1;
                        inst_q  <= inst_rdata;
                        exc_q   <= 32'd0;
                        ds_q    <= br_last;
                    end
                end
                S_FULL: begin
                    if (consume) begin
                        state   <= S_REQ;
                        valid_q <= 1'b0;
                        inst_q  <= 32'd0;
                        exc_q   <= 32'd0;
                        ds_q    <= 1'b0;
                        br_last <= (exc_q == 32'd0) && is_branch(inst_q);
                        if (redirect) begin
                            pc      <= redirect_pc;
                            pending <= 1'b0;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                    end
                end
                S_DISCARD: begin
                    if (inst_data_ok) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef IF_FETCH_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= 32'd0;
            wait_cnt  <= 32'd0;
        end else begin
            if (consume && !flush_i && (exc_q == 32'd0)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (state != S_FULL) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: table of fetch vectors with a small cache responder, plus hand-written flush/reset sequences.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] PC_plus4;
    logic [31:0] Instruction;
    logic        is_delayslot;
    logic [31:0] if_fetch_exc_type;
    logic        fetch_valid;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] wait_cnt;
`endif

    if_fetch_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .flush_pc_i        (flush_pc_i),
        .branch_taken_i    (branch_taken_i),
        .branch_target_i   (branch_target_i),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_addr_ok      (inst_addr_ok),
        .inst_data_ok      (inst_data_ok),
        .inst_rdata        (inst_rdata),
        .PC_plus4          (PC_plus4),
        .Instruction       (Instruction),
        .is_delayslot      (is_delayslot),
        .if_fetch_exc_type (if_fetch_exc_type),
        .fetch_valid       (fetch_valid)
`ifdef IF_FETCH_CNT_EN
        ,
        .fetch_cnt         (fetch_cnt),
        .wait_cnt          (wait_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        taken;
        logic [31:0] target;
        logic        exp_ds;
        int          stall_cyc;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    // packed view: {valid, ds, exc, pc_plus4, instruction}
    logic [97:0] exp_q[$];
    logic [97:0] last_exp;
    int errors;
    int checks;

    function automatic logic [97:0] pack(input logic v, input logic ds, input logic [31:0] exc,
                                         input logic [31:0] pc4, input logic [31:0] ins);
        return {v, ds, exc, pc4, ins};
    endfunction

    function automatic logic [97:0] observed();
        return pack(fetch_valid, is_delayslot, if_fetch_exc_type, PC_plus4, Instruction);
    endfunction

    task automatic check(input string name, input logic [97:0] actual, input logic [97:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_leave_full();
        int n;
        n = 0;
        while (fetch_valid && n < 10) begin
            step();
            n++;
        end
        if (fetch_valid) check("leave_full_timeout", 98'(fetch_valid), 98'd0);
    endtask

    task automatic compare_held(input string name);
        logic [97:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 98'd1, 98'd0);
        end else begin
            e = exp_q.pop_front();
            last_exp = e;
            check(name, observed(), e);
        end
    endtask

    // drives one fetch for vector v through the cache handshake and compares the held result
    task automatic do_fetch(input vec_t v, input int lat_addr, input int lat_data);
        logic [31:0] exc;
        logic [31:0] ins;
        wait_leave_full();
        check("addr", 98'(inst_addr), 98'(v.addr));
        check("bubble", observed(), pack(1'b0, 1'b0, 32'd0, v.addr + 32'd4, 32'd0));
        if (v.addr[1:0] != 2'b00) begin
            check("req_misaligned", 98'(inst_req), 98'd0);
            exp_q.push_back(pack(1'b1, v.exp_ds, 32'h0000_0004, v.addr + 32'd4, 32'd0));
            step();
            compare_held("held_adel");
        end else begin
            check("req", 98'(inst_req), 98'd1);
            repeat (lat_addr) step();
            inst_addr_ok = 1'b1;
            step();
            inst_addr_ok = 1'b0;
            branch_taken_i  = v.taken;
            branch_target_i = v.target;
            step();
            branch_taken_i  = 1'b0;
            branch_target_i = 32'd0;
            repeat (lat_data) step();
            inst_data_ok = 1'b1;
            inst_rdata   = v.rdata;
            exc = 32'd0;
            ins = v.rdata;
            exp_q.push_back(pack(1'b1, v.exp_ds, exc, v.addr + 32'd4, ins));
            step();
            inst_data_ok = 1'b0;
            inst_rdata   = $urandom();
            compare_held("held");
        end
        if (v.stall_cyc > 0) begin
            stall_i = 1'b1;
            for (int i = 0; i < v.stall_cyc; i++) begin
                step();
                check("stall_hold", observed(), last_exp);
                check("stall_req", 98'(inst_req), 98'd0);
            end
            stall_i = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        errors = 0;
        checks = 0;
        vecs[0] = '{32'hBFC0_0000, 32'h2408_0001, 1'b0, 32'd0,          1'b0, 0};
        vecs[1] = '{32'hBFC0_0004, 32'h1000_0003, 1'b0, 32'd0,          1'b0, 0};
        vecs[2] = '{32'hBFC0_0008, 32'h0000_0000, 1'b1, 32'hBFC0_0100, 1'b1, 0};
        vecs[3] = '{32'hBFC0_0100, 32'h0C00_0040, 1'b0, 32'd0,          1'b0, 5};
        vecs[4] = '{32'hBFC0_0104, 32'h0000_0000, 1'b1, 32'hBFC0_0200, 1'b1, 0};
        vecs[5] = '{32'hBFC0_0200, 32'h03E0_0008, 1'b0, 32'd0,          1'b0, 0};
        vecs[6] = '{32'hBFC0_0204, 32'h2409_0002, 1'b0, 32'd0,          1'b1, 0};
        vecs[7] = '{32'hBFC0_0208, 32'h0410_0001, 1'b0, 32'd0,          1'b0, 2};
        vecs[8] = '{32'hBFC0_020C, 32'h0000_0000, 1'b1, 32'hBFC0_0102, 1'b1, 0};
        vecs[9] = '{32'hBFC0_0102, 32'h0000_0000, 1'b0, 32'd0,          1'b0, 0};

        rst_n = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        flush_pc_i = 32'd0;
        branch_taken_i = 1'b0;
        branch_target_i = 32'd0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata = 32'd0;
        repeat (3) step();
        rst_n = 1'b1;

        check("reset_outputs", observed(), pack(1'b0, 1'b0, 32'd0, 32'hBFC0_0004, 32'd0));
        check("reset_req", 98'(inst_req), 98'd1);

        for (int i = 0; i < NV; i++) begin
            do_fetch(vecs[i], (i == 0) ? 0 : $urandom_range(0, 2), (i == 0) ? 1 : $urandom_range(0, 2));
        end

        // flush while an ADEL instruction is held and would be consumed
        flush_i = 1'b1;
        flush_pc_i = 32'hBFC0_0300;
        step();
        flush_i = 1'b0;
        check("flush_full_addr", 98'(inst_addr), 98'hBFC0_0300);
        check("flush_full_valid", 98'(fetch_valid), 98'd0);

        // flush in WAIT, late data is dropped
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        flush_i = 1'b1;
        flush_pc_i = 32'hBFC0_0380;
        step();
        flush_i = 1'b0;
        check("discard_req", 98'(inst_req), 98'd0);
        step();
        step();
        inst_data_ok = 1'b1;
        inst_rdata = 32'hDEAD_BEEF;
        step();
        inst_data_ok = 1'b0;
        check("discard_drop", observed(), pack(1'b0, 1'b0, 32'd0, 32'hBFC0_0384, 32'd0));
        check("discard_next_req", 98'({inst_req, inst_addr}), 98'({1'b1, 32'hBFC0_0380}));

        // flush and data_ok in the same cycle
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        step();
        inst_data_ok = 1'b1;
        inst_rdata = 32'h1234_5678;
        flush_i = 1'b1;
        flush_pc_i = 32'hBFC0_0400;
        step();
        inst_data_ok = 1'b0;
        flush_i = 1'b0;
        check("flush_data_same", observed(), pack(1'b0, 1'b0, 32'd0, 32'hBFC0_0404, 32'd0));
        check("flush_data_req", 98'({inst_req, inst_addr}), 98'({1'b1, 32'hBFC0_0400}));

        // flush in REQ with addr_ok accepted must drain the response
        inst_addr_ok = 1'b1;
        flush_i = 1'b1;
        flush_pc_i = 32'hBFC0_0500;
        step();
        inst_addr_ok = 1'b0;
        flush_i = 1'b0;
        check("flush_req_discard", 98'(inst_req), 98'd0);
        inst_data_ok = 1'b1;
        inst_rdata = 32'hCAFE_0000;
        step();
        inst_data_ok = 1'b0;
        check("flush_req_restart", 98'({fetch_valid, inst_req, inst_addr}), 98'({1'b0, 1'b1, 32'hBFC0_0500}));

        // reset in the middle of WAIT
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        rst_n = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata = 32'h1111_2222;
        step();
        inst_data_ok = 1'b0;
        rst_n = 1'b1;
        check("midwait_reset_outputs", observed(), pack(1'b0, 1'b0, 32'd0, 32'hBFC0_0004, 32'd0));
        check("midwait_reset_req", 98'({inst_req, inst_addr}), 98'({1'b1, 32'hBFC0_0000}));

        // held beq overridden by flush with a same-cycle branch pulse; flush wins and clears br_last
        v = '{32'hBFC0_0000, 32'h1000_0001, 1'b0, 32'd0, 1'b0, 0};
        do_fetch(v, 1, 0);
        flush_i = 1'b1;
        flush_pc_i = 32'hBFC0_0600;
        branch_taken_i = 1'b1;
        branch_target_i = 32'hBFC0_0700;
        step();
        flush_i = 1'b0;
        branch_taken_i = 1'b0;
        branch_target_i = 32'd0;
        v = '{32'hBFC0_0600, 32'h2408_0005, 1'b0, 32'd0, 1'b0, 0};
        do_fetch(v, 0, 1);
        v = '{32'hBFC0_0604, 32'h0000_0009, 1'b0, 32'd0, 1'b0, 0};
        do_fetch(v, 2, 0);

        check("queue_drained", 98'(exp_q.size()), 98'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
